// File: rtl/seg7_disp_arbiter.sv
// Round-robin owner arbiter for the shared 3-digit seven-segment scanner.
// Guarantees a minimum dwell per owner and registers the owner's digits.
module seg7_disp_arbiter #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W = $clog2(DWELL_CYCLES) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [11:0] data0,
  input  logic        req1,
  input  logic [11:0] data1,
  output logic [1:0]  gnt,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DWELL_CYCLES - 1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_owner;
  logic             dwell_done;

  assign dwell_done = (cnt == CNT_MAX);

  // Next owner: voluntary release first, then dwell-gated handover.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (req0 && req1)
          nxt = last_owner ? OWN0 : OWN1;
        else if (req0)
          nxt = OWN0;
        else if (req1)
          nxt = OWN1;
      end
      OWN0: begin
        if (!req0 && req1)
          nxt = OWN1;
        else if (!req0)
          nxt = IDLE;
        else if (dwell_done && req1)
          nxt = OWN1;
      end
      OWN1: begin
        if (!req1 && req0)
          nxt = OWN0;
        else if (!req1)
          nxt = IDLE;
        else if (dwell_done && req0)
          nxt = OWN0;
      end
      default: nxt = IDLE;
    endcase
  end

  // State, registered grant, dwell count and owner digits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      busy       <= 1'b0;
      cnt        <= '0;
      last_owner <= 1'b1;
      digit0     <= 4'h0;
      digit1     <= 4'h0;
      digit2     <= 4'h0;
    end else begin
      state <= nxt;
      gnt   <= {nxt == OWN1, nxt == OWN0};
      busy  <= (nxt != IDLE);
      if (nxt != state && nxt != IDLE) begin
        cnt        <= '0;
        last_owner <= (nxt == OWN1);
      end else if (state != IDLE && !dwell_done) begin
        cnt <= cnt + 1'b1;
      end
      if (state == OWN0) begin
        digit2 <= data0[11:8];
        digit1 <= data0[7:4];
        digit0 <= data0[3:0];
      end else if (state == OWN1) begin
        digit2 <= data1[11:8];
        digit1 <= data1[7:4];
        digit0 <= data1[3:0];
      end
    end
  end

endmodule

// File: tb/tb_seg7_disp_arbiter.sv
// Directed bench for seg7_disp_arbiter with DWELL_CYCLES = 4.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_seg7_disp_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [11:0] data0 = 12'h000;
  logic [11:0] data1 = 12'h000;
  logic [1:0]  gnt;
  logic [3:0]  digit0;
  logic [3:0]  digit1;
  logic [3:0]  digit2;
  logic        busy;

  int checks = 0;
  int errors = 0;

  seg7_disp_arbiter #(.DWELL_CYCLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .data0  (data0),
    .req1   (req1),
    .data1  (data1),
    .gnt    (gnt),
    .digit0 (digit0),
    .digit1 (digit1),
    .digit2 (digit2),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] digs();
    return {4'h0, digit2, digit1, digit0};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // 1. reset and first grant
    req0  = 1'b1;
    data0 = 12'h123;
    data1 = 12'hABC;
    tick();
    tick();
    chk("rst_gnt", {14'd0, gnt}, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'h0000);
    chk("rst_dig", digs(), 16'h0000);
    rst_n = 1'b1;
    tick();
    chk("g1_gnt", {14'd0, gnt}, 16'h0001);
    chk("g1_busy", {15'd0, busy}, 16'h0001);
    chk("g1_dig_lat", digs(), 16'h0000);
    tick();
    chk("g1_dig", digs(), 16'h0123);

    // 2. tie and round-robin
    req1 = 1'b1;
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("rr_gnt", {14'd0, gnt},
          (((i - 1) / 4) % 2) != 0 ? 16'h0002 : 16'h0001);
      if (i >= 2)
        chk("rr_dig", digs(),
            (((i - 2) / 4) % 2) != 0 ? 16'h0ABC : 16'h0123);
    end

    // 3a. early release with other waiting
    do_reset();
    tick();
    tick();
    chk("er_gnt0", {14'd0, gnt}, 16'h0001);
    req0 = 1'b0;
    tick();
    chk("er_gnt1", {14'd0, gnt}, 16'h0002);
    tick();
    chk("er_dig1", digs(), 16'h0ABC);

    // 3b. early release with nobody waiting
    req0 = 1'b1;
    req1 = 1'b0;
    do_reset();
    tick();
    tick();
    req0 = 1'b0;
    tick();
    chk("rel_gnt", {14'd0, gnt}, 16'h0000);
    chk("rel_busy", {15'd0, busy}, 16'h0000);
    data0 = 12'h999;
    tick();
    chk("rel_hold", digs(), 16'h0123);

    // 4. data tracking
    req0  = 1'b1;
    data0 = 12'h123;
    do_reset();
    tick();
    tick();
    chk("trk_a", digs(), 16'h0123);
    data0 = 12'h456;
    data1 = 12'hFFF;
    tick();
    chk("trk_b", digs(), 16'h0456);
    data1 = 12'h777;
    tick();
    chk("trk_c", digs(), 16'h0456);
    chk("trk_gnt", {14'd0, gnt}, 16'h0001);

    // 5. lone requester, then late contender
    data1 = 12'hABC;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("lone_gnt", {14'd0, gnt}, 16'h0001);
    end
    req1 = 1'b1;
    tick();
    chk("late_gnt", {14'd0, gnt}, 16'h0002);
    tick();
    chk("late_dig", digs(), 16'h0ABC);

    // 6. reset mid-ownership
    rst_n = 1'b0;
    tick();
    chk("mr_gnt", {14'd0, gnt}, 16'h0000);
    chk("mr_busy", {15'd0, busy}, 16'h0000);
    chk("mr_dig", digs(), 16'h0000);
    rst_n = 1'b1;
    tick();
    chk("mr_first", {14'd0, gnt}, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
